// File: rtl/imsic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imsic_pkg
//  Purpose  : Shared types and helpers for one IMSIC interrupt file.
//  Revision : 1.0 - initial release
// ============================================================================
package imsic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PUBLISH = 2'd2
    } scan_state_t;

    // Register array select: 0 = pending bits, 1 = enable bits.
    localparam logic c_sel_eip = 1'b0;
    localparam logic c_sel_eie = 1'b1;
    localparam int   c_reg_w   = 32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imsic_prio_chunk.sv
`default_nettype none
// ============================================================================
//  Module   : imsic_prio_chunk
//  Purpose  : Find-first-set over one scan chunk (lowest set bit wins).
//  Revision : 1.0 - initial release
// ============================================================================
module imsic_prio_chunk
    import imsic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OFF_W = id_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_hit,
    output logic [OFF_W-1:0] o_off
);

    always_comb begin
        o_hit = |i_vec;
        o_off = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) o_off = OFF_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/imsic_intp_file.sv
`default_nettype none
// ============================================================================
//  Module   : imsic_intp_file
//  Purpose  : IMSIC interrupt file: eip/eie arrays, multi-cycle top-id scanner.
//             Optional IMSIC_THRESHOLD_EN adds the i_eithreshold port.
//  Revision : 1.0 - initial release
// ============================================================================
module imsic_intp_file
    import imsic_pkg::*;
#(
    parameter int NR_SRC     = 64,
    parameter int NR_SRC_LEN = 32,
    parameter int SCAN_CHUNK = 32,
    parameter int ID_W       = id_width(NR_SRC),
    parameter int IDX_W      = id_width(NR_SRC / c_reg_w)
) (
    input  logic                  i_clk,
    input  logic                  ni_rst,
    input  logic [NR_SRC_LEN-1:0] i_setipnum,
    input  logic                  i_setipnum_we,
    input  logic                  i_reg_we,
    input  logic                  i_reg_re,
    input  logic                  i_reg_sel,
    input  logic [IDX_W-1:0]      i_reg_idx,
    input  logic [31:0]           i_reg_wdata,
    output logic [31:0]           o_reg_rdata,
    input  logic                  i_eidelivery,
`ifdef IMSIC_THRESHOLD_EN
    input  logic [ID_W-1:0]       i_eithreshold,
`endif
    input  logic                  i_claim,
    output logic [ID_W-1:0]       o_topei,
    output logic                  o_irq
);

    localparam int NR_CHUNK = NR_SRC / SCAN_CHUNK;
    localparam int CHUNK_W  = id_width(NR_CHUNK);
    localparam int OFF_W    = id_width(SCAN_CHUNK);

    logic [NR_SRC-1:0]     r_eip, r_eie, w_eip_nxt, w_eie_nxt;
    logic [31:0]           r_reg_rdata;
    scan_state_t           r_state;
    logic [CHUNK_W-1:0]    r_chunk;
    logic                  r_restart, r_best_hit;
    logic [ID_W-1:0]       r_best_id, r_topei, w_hit_id;
    logic [SCAN_CHUNK-1:0] w_cand;
    logic                  w_hit, w_set_ok, w_dirty, w_thr_dirty;
    logic [OFF_W-1:0]      w_off;
    int                    w_word_lsb, w_chunk_lsb;

    assign w_word_lsb = int'(i_reg_idx) * c_reg_w;
    assign w_set_ok   = i_setipnum_we && (i_setipnum != '0) &&
                        (i_setipnum < NR_SRC_LEN'(NR_SRC));

    // Applied lowest to highest priority: word write, claim clear, setipnum set.
    always_comb begin
        w_eip_nxt = r_eip;
        w_eie_nxt = r_eie;
        if (i_reg_we) begin
            if (i_reg_sel == c_sel_eip) w_eip_nxt[w_word_lsb +: c_reg_w] = i_reg_wdata;
            else                        w_eie_nxt[w_word_lsb +: c_reg_w] = i_reg_wdata;
        end
        if (i_claim && (r_topei != '0)) w_eip_nxt[r_topei] = 1'b0;
        if (w_set_ok) w_eip_nxt[i_setipnum[ID_W-1:0]] = 1'b1;
        w_eip_nxt[0] = 1'b0;
        w_eie_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_eip       <= '0;
            r_eie       <= '0;
            r_reg_rdata <= '0;
        end else begin
            r_eip <= w_eip_nxt;
            r_eie <= w_eie_nxt;
            if (i_reg_re) begin
                r_reg_rdata <= (i_reg_sel == c_sel_eie) ? r_eie[w_word_lsb +: c_reg_w]
                                                        : r_eip[w_word_lsb +: c_reg_w];
            end
        end
    end

`ifdef IMSIC_THRESHOLD_EN
    logic [ID_W-1:0] r_thr_q;

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) r_thr_q <= '0;
        else         r_thr_q <= i_eithreshold;
    end

    assign w_thr_dirty = (i_eithreshold != r_thr_q);

    always_comb begin
        w_chunk_lsb = int'(r_chunk) * SCAN_CHUNK;
        w_cand      = r_eip[w_chunk_lsb +: SCAN_CHUNK] & r_eie[w_chunk_lsb +: SCAN_CHUNK];
        for (int j = 0; j < SCAN_CHUNK; j++) begin
            if ((i_eithreshold != '0) && ((w_chunk_lsb + j) >= int'(i_eithreshold)))
                w_cand[j] = 1'b0;
        end
    end
`else
    assign w_thr_dirty = 1'b0;

    always_comb begin
        w_chunk_lsb = int'(r_chunk) * SCAN_CHUNK;
        w_cand      = r_eip[w_chunk_lsb +: SCAN_CHUNK] & r_eie[w_chunk_lsb +: SCAN_CHUNK];
    end
`endif

    assign w_dirty = i_setipnum_we | i_reg_we | i_claim | w_thr_dirty;

    imsic_prio_chunk #(
        .WIDTH (SCAN_CHUNK),
        .OFF_W (OFF_W)
    ) u_prio_chunk (
        .i_vec (w_cand),
        .o_hit (w_hit),
        .o_off (w_off)
    );

    assign w_hit_id = ID_W'(w_chunk_lsb + int'(w_off));

    // r_restart comes out of reset set so the first scan runs unprompted.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_state    <= IDLE;
            r_chunk    <= '0;
            r_restart  <= 1'b1;
            r_best_hit <= 1'b0;
            r_best_id  <= '0;
            r_topei    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dirty || r_restart) begin
                        r_state    <= SCAN;
                        r_chunk    <= '0;
                        r_restart  <= 1'b0;
                        r_best_hit <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_dirty) r_restart <= 1'b1;
                    if (w_hit && !r_best_hit) begin
                        r_best_hit <= 1'b1;
                        r_best_id  <= w_hit_id;
                    end
                    if (r_chunk == CHUNK_W'(NR_CHUNK - 1)) begin
                        r_chunk <= '0;
                        r_state <= PUBLISH;
                    end else begin
                        r_chunk <= r_chunk + CHUNK_W'(1);
                    end
                end
                PUBLISH: begin
                    r_topei <= r_best_hit ? r_best_id : '0;
                    if (w_dirty || r_restart) begin
                        r_state    <= SCAN;
                        r_chunk    <= '0;
                        r_restart  <= 1'b0;
                        r_best_hit <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_topei     = r_topei;
    assign o_reg_rdata = r_reg_rdata;
    assign o_irq       = (r_topei != '0) && i_eidelivery;

endmodule
`default_nettype wire

// File: tb/tb_imsic_intp_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imsic_intp_file
//  Purpose  : Randomized self-checking bench for imsic_intp_file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imsic_intp_file;

    localparam int NR_SRC = 64;
    localparam int ID_W   = 6;
    localparam int SETTLE = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     setipnum = '0;
    logic            setipnum_we = 1'b0;
    logic            reg_we = 1'b0, reg_re = 1'b0, reg_sel = 1'b0;
    logic [0:0]      reg_idx = '0;
    logic [31:0]     reg_wdata = '0;
    logic [31:0]     reg_rdata;
    logic            deliv = 1'b0;
    logic            claim_p = 1'b0;
    logic [ID_W-1:0] topei;
    logic            irq;
`ifdef IMSIC_THRESHOLD_EN
    logic [ID_W-1:0] thr = '0;
`endif

    bit m_eip [NR_SRC];
    bit m_eie [NR_SRC];
    int m_thr = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imsic_intp_file dut (
        .i_clk         (clk),
        .ni_rst        (rst_n),
        .i_setipnum    (setipnum),
        .i_setipnum_we (setipnum_we),
        .i_reg_we      (reg_we),
        .i_reg_re      (reg_re),
        .i_reg_sel     (reg_sel),
        .i_reg_idx     (reg_idx),
        .i_reg_wdata   (reg_wdata),
        .o_reg_rdata   (reg_rdata),
        .i_eidelivery  (deliv),
`ifdef IMSIC_THRESHOLD_EN
        .i_eithreshold (thr),
`endif
        .i_claim       (claim_p),
        .o_topei       (topei),
        .o_irq         (irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_top();
        for (int id = 1; id < NR_SRC; id++) begin
            if (m_eip[id] && m_eie[id] && (m_thr == 0 || id < m_thr)) return id;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_word(input bit sel, input int idx);
        logic [31:0] w;
        for (int b = 0; b < 32; b++) w[b] = sel ? m_eie[idx*32+b] : m_eip[idx*32+b];
        return w;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NR_SRC; i++) begin
            m_eip[i] = 1'b0;
            m_eie[i] = 1'b0;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ip(input logic [31:0] id);
        setipnum    = id;
        setipnum_we = 1'b1;
        @(negedge clk);
        setipnum_we = 1'b0;
        if (id != 0 && id < NR_SRC) m_eip[id] = 1'b1;
    endtask

    task automatic reg_write(input bit sel, input int idx, input logic [31:0] data);
        reg_we    = 1'b1;
        reg_sel   = sel;
        reg_idx   = 1'(idx);
        reg_wdata = data;
        @(negedge clk);
        reg_we = 1'b0;
        for (int b = 0; b < 32; b++) begin
            if (sel) m_eie[idx*32+b] = data[b];
            else     m_eip[idx*32+b] = data[b];
        end
        m_eip[0] = 1'b0;
        m_eie[0] = 1'b0;
    endtask

    task automatic reg_read(input string tag, input bit sel, input int idx);
        reg_re  = 1'b1;
        reg_sel = sel;
        reg_idx = 1'(idx);
        @(negedge clk);
        reg_re = 1'b0;
        check(tag, reg_rdata, model_word(sel, idx));
    endtask

    task automatic claim();
        int t;
        t = model_top();
        claim_p = 1'b1;
        @(negedge clk);
        claim_p = 1'b0;
        if (t != 0) m_eip[t] = 1'b0;
    endtask

    task automatic check_top(input string tag);
        check({tag, "_topei"}, topei, model_top());
        check({tag, "_irq"}, irq, (model_top() != 0) && deliv);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        idle(3);
        check("rst_topei", topei, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", reg_rdata, 0);
        rst_n = 1'b1;
        idle(SETTLE);
        check_top("boot");

        // Invalid setipnum identities are dropped.
        reg_write(1'b1, 0, 32'hFFFF_FFFF);
        reg_read("eie0_bit0_dropped", 1'b1, 0);
        set_ip(32'd0);
        set_ip(32'd64);
        set_ip(32'd65);
        set_ip(32'hFFFF_FFFF);
        idle(SETTLE);
        check_top("invalid_ids");
        reg_read("invalid_eip0", 1'b0, 0);
        reg_read("invalid_eip1", 1'b0, 1);

        // Exact event-to-publish latency.
        deliv = 1'b1;
        set_ip(32'd5);
        idle(1);
        check("lat_e2", topei, 0);
        idle(1);
        check("lat_e3", topei, 0);
        idle(1);
        check("lat_e4", topei, 5);
        check("lat_irq_on", irq, 1);
        deliv = 1'b0;
        #1;
        check("lat_irq_off", irq, 0);
        idle(1);

        // Claim exposes the next identity.
        reg_write(1'b0, 0, 32'h0);
        reg_write(1'b1, 1, 32'hFFFF_FFFF);
        set_ip(32'd40);
        set_ip(32'd7);
        idle(SETTLE);
        check_top("two_pending");
        claim();
        reg_read("claim_eip0", 1'b0, 0);
        idle(SETTLE);
        check_top("after_claim");

        // Set wins over claim and over a word write on the same bit.
        set_ip(32'd7);
        idle(SETTLE);
        check_top("reset_7");
        claim_p = 1'b1;
        setipnum = 32'd7;
        setipnum_we = 1'b1;
        @(negedge clk);
        claim_p = 1'b0;
        setipnum_we = 1'b0;
        idle(SETTLE);
        check_top("claim_vs_set");
        reg_read("claim_vs_set_eip0", 1'b0, 0);
        reg_we = 1'b1; reg_sel = 1'b0; reg_idx = 1'b0; reg_wdata = 32'h0;
        setipnum = 32'd3; setipnum_we = 1'b1;
        @(negedge clk);
        reg_we = 1'b0; setipnum_we = 1'b0;
        for (int b = 0; b < 32; b++) m_eip[b] = 1'b0;
        m_eip[3] = 1'b1;
        idle(SETTLE);
        check_top("write_vs_set");
        reg_read("write_vs_set_eip0", 1'b0, 0);

        // Read and write to the same word in one cycle returns the old word.
        reg_re = 1'b1;
        reg_write(1'b0, 1, 32'hA5A5_0000);
        reg_re = 1'b0;
        check("rw_same_cycle", reg_rdata, 32'h0000_0100);
        idle(SETTLE);

        // Continuous setipnum stream keeps restarting the scan.
        reg_write(1'b0, 0, 32'h0);
        reg_write(1'b0, 1, 32'h0);
        reg_write(1'b1, 0, 32'hFFFF_FFFF);
        setipnum_we = 1'b1;
        for (int i = 0; i < 14; i++) begin
            logic [31:0] id;
            id = (i == 11) ? 32'd2 : 32'($urandom_range(63, 4));
            setipnum = id;
            m_eip[id] = 1'b1;
            @(negedge clk);
        end
        setipnum_we = 1'b0;
        idle(SETTLE);
        check_top("burst");
        reg_read("burst_eip0", 1'b0, 0);
        reg_read("burst_eip1", 1'b0, 1);

        // Randomized mix against the reference model.
        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(0, 4);
            case (op)
                0, 1: set_ip(($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 70)));
                2: reg_write(1'b0, $urandom_range(0, 1), $urandom & $urandom);
                3: reg_write(1'b1, $urandom_range(0, 1), $urandom | $urandom);
                default: claim();
            endcase
            deliv = 1'($urandom_range(0, 1));
            idle(SETTLE);
            check_top("rand");
            if (it % 5 == 0) begin
                reg_read("rand_eip", 1'b0, $urandom_range(0, 1));
                reg_read("rand_eie", 1'b1, $urandom_range(0, 1));
            end
        end

        // Asynchronous reset in the middle of a scan.
        reg_write(1'b1, 0, 32'hFFFF_FFFF);
        set_ip(32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("midrst_topei", topei, 0);
        check("midrst_irq", irq, 0);
        check("midrst_rdata", reg_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(SETTLE);
        check_top("post_rst");
        reg_read("post_rst_eip0", 1'b0, 0);
        reg_read("post_rst_eie0", 1'b1, 0);

`ifdef IMSIC_THRESHOLD_EN
        reg_write(1'b1, 0, 32'hFFFF_FFFF);
        set_ip(32'd12);
        set_ip(32'd9);
        thr = 6'd10;
        m_thr = 10;
        idle(SETTLE);
        check("thr10_topei", topei, 9);
        thr = 6'd9;
        m_thr = 9;
        idle(SETTLE);
        check("thr9_topei", topei, 0);
        thr = 6'd0;
        m_thr = 0;
        idle(SETTLE);
        check_top("thr0");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
